// File: rtl/matmul_spi_sequencer.sv
// SPI mode-0 master that turns an opcode/length command plus a byte stream into one
// chip-select frame for the matrix multiplier, returning captured read bytes.
module matmul_spi_sequencer #(
  parameter int unsigned CLK_DIV = 4,
  parameter int unsigned LEN_W   = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [7:0]       cmd_opcode,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic             tx_valid,
  input  logic [7:0]       tx_data,
  output logic             tx_ready,
  output logic             rx_valid,
  output logic [7:0]       rx_data,
  input  logic             abort,
  output logic             spi_csb,
  output logic             spi_clk,
  output logic             spi_sdi,
  input  logic             spi_sdo,
  output logic             busy,
  output logic             done,
  output logic             aborted
);

  localparam int unsigned BitW      = LEN_W + 3;
  localparam logic [7:0]  PhaseLast = 8'(CLK_DIV - 1);
  localparam logic [7:0]  GapDone   = 8'(CLK_DIV - 2);

  typedef enum logic [2:0] {StIdle, StSetup, StShift, StHold, StGap} state_e;

  state_e            state_q;
  logic [7:0]        cnt_q;
  logic [BitW-1:0]   bit_q;
  logic [LEN_W-1:0]  len_q;
  logic              high_q;
  logic              stall_q;
  logic              abort_q;
  logic              rd_q;
  logic [6:0]        sh_q;
  logic [6:0]        rx_sh_q;

  logic phase_end;
  logic abort_now;
  logic last_bit;
  logic byte_end;
  logic rx_byte;

  assign phase_end = (cnt_q == PhaseLast);
  assign abort_now = abort_q | abort;
  assign last_bit  = (bit_q == {len_q, 3'b111});
  assign byte_end  = (bit_q[2:0] == 3'b111);
  // Opcode-byte samples never produce a read byte.
  assign rx_byte   = rd_q && byte_end && (bit_q[BitW-1:3] != '0) && !abort_now;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      bit_q     <= '0;
      len_q     <= '0;
      high_q    <= 1'b0;
      stall_q   <= 1'b0;
      abort_q   <= 1'b0;
      rd_q      <= 1'b0;
      sh_q      <= '0;
      rx_sh_q   <= '0;
      cmd_ready <= 1'b1;
      tx_ready  <= 1'b0;
      rx_valid  <= 1'b0;
      rx_data   <= '0;
      spi_csb   <= 1'b1;
      spi_clk   <= 1'b0;
      spi_sdi   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      aborted   <= 1'b0;
    end else begin
      tx_ready <= 1'b0;
      rx_valid <= 1'b0;
      done     <= 1'b0;
      aborted  <= 1'b0;
      case (state_q)
        StIdle: begin
          if (cmd_valid) begin
            len_q     <= cmd_len;
            rd_q      <= cmd_opcode[7];
            sh_q      <= cmd_opcode[6:0];
            spi_sdi   <= cmd_opcode[7];
            spi_csb   <= 1'b0;
            spi_clk   <= 1'b0;
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
            abort_q   <= 1'b0;
            cnt_q     <= '0;
            state_q   <= StSetup;
          end
        end

        StSetup: begin
          if (abort) abort_q <= 1'b1;
          if (phase_end) begin
            cnt_q   <= '0;
            bit_q   <= '0;
            high_q  <= 1'b0;
            stall_q <= 1'b0;
            state_q <= abort_now ? StHold : StShift;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end

        StShift: begin
          if (stall_q) begin
            // SCLK parked low waiting for write data; abort leaves immediately.
            if (abort_now) begin
              abort_q <= 1'b1;
              stall_q <= 1'b0;
              cnt_q   <= '0;
              state_q <= StHold;
            end else if (tx_valid) begin
              sh_q     <= tx_data[6:0];
              spi_sdi  <= tx_data[7];
              tx_ready <= 1'b1;
              stall_q  <= 1'b0;
              cnt_q    <= '0;
              high_q   <= 1'b0;
            end
          end else begin
            if (abort) abort_q <= 1'b1;
            if (!phase_end) begin
              cnt_q <= cnt_q + 8'd1;
            end else begin
              cnt_q <= '0;
              if (!high_q) begin
                if (abort_now) begin
                  state_q <= StHold;
                end else begin
                  high_q  <= 1'b1;
                  spi_clk <= 1'b1;
                end
              end else begin
                high_q  <= 1'b0;
                spi_clk <= 1'b0;
                rx_sh_q <= {rx_sh_q[5:0], spi_sdo};
                if (rx_byte) begin
                  rx_data  <= {rx_sh_q, spi_sdo};
                  rx_valid <= 1'b1;
                end
                if (abort_now || last_bit) begin
                  state_q <= StHold;
                end else begin
                  bit_q <= bit_q + 1'b1;
                  if (!byte_end) begin
                    spi_sdi <= sh_q[6];
                    sh_q    <= {sh_q[5:0], 1'b0};
                  end else if (rd_q) begin
                    spi_sdi <= 1'b0;
                    sh_q    <= '0;
                  end else if (tx_valid) begin
                    spi_sdi  <= tx_data[7];
                    sh_q     <= tx_data[6:0];
                    tx_ready <= 1'b1;
                  end else begin
                    stall_q <= 1'b1;
                  end
                end
              end
            end
          end
        end

        StHold: begin
          if (phase_end) begin
            cnt_q   <= '0;
            spi_csb <= 1'b1;
            spi_sdi <= 1'b0;
            state_q <= StGap;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end

        StGap: begin
          // done/aborted are registered, so raise them one edge before GAP ends.
          if (cnt_q == GapDone) begin
            done    <= 1'b1;
            aborted <= abort_q;
          end
          if (phase_end) begin
            cnt_q     <= '0;
            busy      <= 1'b0;
            cmd_ready <= 1'b1;
            state_q   <= StIdle;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end

        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
